besdpb: RTL and testbench

BESDPB -- requirements
Module: besdpb

---
 rtl/besdpb.sv | 55 +++++
 tb/tb_besdpb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/besdpb.sv
// Byte-enabled single-address semi-dual-port synchronous RAM (read-first).
//
// Ports:
//   clk          - single clock, all state changes on its rising edge
//   rst_n        - asynchronous active-low reset (clears data_out only)
//   write_enable - per-byte write strobe, bit i selects data bits 8i+7:8i
//   address      - word index shared by the read and write paths
//   data_in      - write data
//   data_out     - registered read data, one-cycle latency
//
// Memory contents are never reset: they survive rst_n pulses, and words
// that were never written read back as undefined.
module besdpb #(
    parameter int unsigned ADDRESS_BITWIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  write_enable,
    input  logic [ADDRESS_BITWIDTH-1:0] address,
    input  logic [31:0]                 data_in,
    output logic [31:0]                 data_out
);

    localparam int unsigned NUM_BYTES = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned DATA_W    = NUM_BYTES * BYTE_W;
    localparam int unsigned DEPTH     = 2 ** ADDRESS_BITWIDTH;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_out_d;
    logic [DATA_W-1:0] data_out_q;

    // Read the stored word; the write below lands after this sample (read-first).
    always_comb begin
        data_out_d = mem_q[address];
    end

    // The reset branch has priority, so writes are suppressed while rst_n is low
    // and the memory array itself is never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (write_enable[i]) begin
                    mem_q[address][i*BYTE_W +: BYTE_W] <= data_in[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_besdpb.sv
// Scoreboard bench for besdpb: the driver predicts each read from a
// byte-level memory model and queues it; the monitor compares after each edge.
module tb_besdpb;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 2 ** AW;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  known;
        logic [7:0]  addr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  write_enable;
    logic [AW-1:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    logic [31:0] model [DEPTH];
    logic [3:0]  known [DEPTH];
    exp_t        exp_q [$];

    int checks   = 0;
    int failures = 0;

    besdpb #(.ADDRESS_BITWIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] lane_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic [3:0] we, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        write_enable = we;
        address      = a;
        data_in      = d;
        if (rst_n) begin
            e.data  = model[a];
            e.known = known[a];
            e.addr  = a;
            exp_q.push_back(e);
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    model[a][i*8 +: 8] = d[i*8 +: 8];
                    known[a][i]        = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (data_out !== 32'h0) begin
            failures++;
            $display("FAIL %s: data_out=%08h expected=00000000", name, data_out);
        end
    endtask

    // Monitor: every active edge with rst_n high produces one read result.
    always @(posedge clk) begin
        exp_t e;
        logic [31:0] m;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = lane_mask(e.known);
            checks++;
            if (((data_out ^ e.data) & m) != 32'h0) begin
                failures++;
                $display("FAIL read@%0d: data_out=%08h expected=%08h mask=%08h",
                         e.addr, data_out, e.data, m);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 32'h0;
            known[i] = 4'b0000;
        end
        rst_n        = 1'b0;
        write_enable = 4'b0000;
        address      = '0;
        data_in      = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_initial");
        rst_n = 1'b1;

        // Full write then read
        cycle(4'b1111, 8'd5, 32'hDEAD_BEEF);
        cycle(4'b0000, 8'd5, 32'h0);
        // Single byte lane update
        cycle(4'b0010, 8'd5, 32'h0000_AA00);
        cycle(4'b0000, 8'd5, 32'h0);
        // Read-first behaviour at address 7
        cycle(4'b1111, 8'd7, 32'h1111_1111);
        cycle(4'b1111, 8'd7, 32'h2222_2222);
        cycle(4'b0000, 8'd7, 32'h0);
        // Accumulating partial writes
        cycle(4'b0001, 8'd9, 32'h0000_0011);
        cycle(4'b0100, 8'd9, 32'h0033_0000);
        cycle(4'b1010, 8'd9, 32'h4400_2200);
        cycle(4'b0000, 8'd9, 32'h0);
        // Address extremes
        cycle(4'b1111, 8'd0,   32'hA5A5_A5A5);
        cycle(4'b1111, 8'd255, 32'h5A5A_5A5A);
        // Back-to-back alternating reads
        for (int i = 0; i < 6; i++) cycle(4'b0000, (i % 2 == 0) ? 8'd0 : 8'd255, 32'h0);

        // Asynchronous reset mid-test, with a write attempted during reset
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        cycle(4'b1111, 8'd5, 32'h0BAD_0BAD);
        cycle(4'b1111, 8'd5, 32'h0BAD_0BAD);
        check_zero("reset_held");
        rst_n = 1'b1;
        cycle(4'b0000, 8'd5, 32'h0);
        cycle(4'b0000, 8'd0, 32'h0);
        cycle(4'b0000, 8'd255, 32'h0);

        // Random traffic concentrated on a few hot addresses
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] a;
            logic [31:0] r;
            r = $urandom;
            case (r[1:0])
                2'd0: a = 8'd0;
                2'd1: a = 8'd255;
                2'd2: a = 8'($urandom_range(0, 7));
                default: a = 8'($urandom);
            endcase
            cycle(4'($urandom), a, $urandom);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
